fpnew_sdotp_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one in-order, pipelined SDOTP/VSUM unit between `NumReq` requesters, such as several issue ports or lanes feeding a single `fpnew_sdotp_multi_wrapper` instance. It grants one requester per accepted issue and records the granted requester ID in an in-flight ID FIFO. It uses that FIFO to route each returning result back to the requester that issued it. Requests and results are opaque payloads, so the block is independent of format configuration.

---
 rtl/fpnew_sdotp_rr_arbiter_if.sv | 45 ++++
 rtl/fpnew_sdotp_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fpnew_sdotp_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_sdotp_rr_arbiter_if.sv
// +----------------------------------------------------------------------------
// | fpnew_sdotp_rr_arbiter_if: request, issue and response bundle of the arbiter
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface fpnew_sdotp_rr_arbiter_if #(
    parameter int unsigned NumReq      = 2,
    parameter type         PayloadType = logic,
    parameter type         ResultType  = logic
);
    logic                    flush_i;
    logic [NumReq-1:0]       req_valid_i;
    logic [NumReq-1:0]       req_ready_o;
    PayloadType              req_payload_i [NumReq];
    logic                    unit_valid_o;
    logic                    unit_ready_i;
    PayloadType              unit_payload_o;
    logic                    unit_flush_o;
    logic                    unit_out_valid_i;
    logic                    unit_out_ready_o;
    ResultType               unit_result_i;
    logic [NumReq-1:0]       rsp_valid_o;
    logic [NumReq-1:0]       rsp_ready_i;
    ResultType               rsp_result_o;
    logic                    busy_o;

    // The arbiter serves requests, so it takes the slave view; requesters and
    // the shared unit together form the master side.
    modport slave (
        input  flush_i, req_valid_i, req_payload_i, unit_ready_i,
               unit_out_valid_i, unit_result_i, rsp_ready_i,
        output req_ready_o, unit_valid_o, unit_payload_o, unit_flush_o,
               unit_out_ready_o, rsp_valid_o, rsp_result_o, busy_o
    );

    modport master (
        output flush_i, req_valid_i, req_payload_i, unit_ready_i,
               unit_out_valid_i, unit_result_i, rsp_ready_i,
        input  req_ready_o, unit_valid_o, unit_payload_o, unit_flush_o,
               unit_out_ready_o, rsp_valid_o, rsp_result_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/fpnew_sdotp_rr_arbiter.sv
// +----------------------------------------------------------------------------
// | fpnew_sdotp_rr_arbiter: round-robin sharing of one in-order SDOTP/VSUM unit
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module fpnew_sdotp_rr_arbiter #(
    parameter int unsigned NumReq      = 2,
    parameter int unsigned MaxInFlight = 4,
    parameter type         PayloadType = logic,
    parameter type         ResultType  = logic
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    fpnew_sdotp_rr_arbiter_if.slave         bus
);
    localparam int unsigned IdWidth  = $clog2(NumReq);
    localparam int unsigned CntWidth = $clog2(MaxInFlight + 1);
    localparam int unsigned PtrWidth = (MaxInFlight > 1) ? $clog2(MaxInFlight) : 1;

    typedef logic [IdWidth-1:0]  id_t;
    typedef logic [PtrWidth-1:0] ptr_t;

    id_t                 prio_q;
    logic                lock_q;
    id_t                 lock_id_q;
    logic [CntWidth-1:0] cnt_q;
    ptr_t                wr_ptr_q;
    ptr_t                rd_ptr_q;
    id_t                 id_fifo_q [MaxInFlight];

    id_t        rr_grant;
    logic       rr_found;
    id_t        rr_idx;
    id_t        grant;
    id_t        head;
    logic       can_issue;
    logic       issue_req;
    logic       unit_valid;
    logic       push;
    logic       pop;
    logic       in_flight;
    logic       out_ready;
    PayloadType unit_payload;
    ResultType  rsp_result;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (32'(p) == MaxInFlight - 1) ? '0 : p + PtrWidth'(1);
    endfunction

    // First valid requester at or after the priority pointer, wrapping.
    always_comb begin
        rr_grant = prio_q;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            rr_idx = id_t'((32'(prio_q) + i) % NumReq);
            if (!rr_found && bus.req_valid_i[rr_idx]) begin
                rr_grant = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    assign grant      = lock_q ? lock_id_q : rr_grant;
    assign issue_req  = lock_q ? bus.req_valid_i[lock_id_q] : (|bus.req_valid_i);
    assign can_issue  = (cnt_q < CntWidth'(MaxInFlight));
    assign unit_valid = can_issue && issue_req;
    assign push       = unit_valid && bus.unit_ready_i && !bus.flush_i;

    assign head       = id_fifo_q[rd_ptr_q];
    assign in_flight  = (cnt_q != '0);
    assign out_ready  = bus.rsp_ready_i[head] && in_flight;
    assign pop        = bus.unit_out_valid_i && out_ready && !bus.flush_i;

    assign unit_payload = bus.req_payload_i[grant];
    assign rsp_result   = bus.unit_result_i;

    always_comb begin
        bus.req_ready_o = '0;
        if (push) begin
            bus.req_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        bus.rsp_valid_o = '0;
        if (bus.unit_out_valid_i && in_flight && !bus.flush_i) begin
            bus.rsp_valid_o[head] = 1'b1;
        end
    end

    assign bus.unit_valid_o     = unit_valid;
    assign bus.unit_payload_o   = unit_payload;
    assign bus.unit_flush_o     = bus.flush_i;
    assign bus.unit_out_ready_o = out_ready;
    assign bus.rsp_result_o     = rsp_result;
    assign bus.busy_o           = in_flight || (|bus.req_valid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q    <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else if (bus.flush_i) begin
            // Priority pointer survives a flush so fairness carries across it.
            lock_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
                prio_q   <= id_t'((32'(grant) + 1) % NumReq);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
            if (unit_valid && !bus.unit_ready_i) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end else if (push) begin
                lock_q <= 1'b0;
            end
        end
    end

    // ID storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_fifo_q[wr_ptr_q] <= grant;
        end
    end

    a_no_orphan_result: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(bus.unit_out_valid_i && (cnt_q == '0))
    ) else $error("unit result arrived with no request in flight");

endmodule

`default_nettype wire

// File: tb/tb_fpnew_sdotp_rr_arbiter.sv
// +----------------------------------------------------------------------------
// | tb_fpnew_sdotp_rr_arbiter: directed self-checking bench for the arbiter
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_fpnew_sdotp_rr_arbiter;
    typedef logic [15:0] payload_t;
    typedef logic [15:0] result_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fpnew_sdotp_rr_arbiter_if #(
        .NumReq      (2),
        .PayloadType (payload_t),
        .ResultType  (result_t)
    ) bus ();

    fpnew_sdotp_rr_arbiter #(
        .NumReq      (2),
        .MaxInFlight (4),
        .PayloadType (payload_t),
        .ResultType  (result_t)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i          = 1'b0;
        bus.req_valid_i      = 2'b00;
        bus.req_payload_i[0] = '0;
        bus.req_payload_i[1] = '0;
        bus.unit_ready_i     = 1'b0;
        bus.unit_out_valid_i = 1'b0;
        bus.unit_result_i    = '0;
        bus.rsp_ready_i      = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.rsp_ready_i = 2'b11;
        settle();
        check("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        check("rst_unit_valid", 32'(bus.unit_valid_o), 32'h0);
        check("rst_out_ready", 32'(bus.unit_out_ready_o), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        do_reset();
        next_cycle();

        // Single requester, three back-to-back issues, unit latency two.
        bus.req_valid_i = 2'b01;
        bus.unit_ready_i = 1'b1;
        bus.rsp_ready_i = 2'b01;
        for (int c = 0; c < 6; c++) begin
            bus.req_valid_i      = (c < 3) ? 2'b01 : 2'b00;
            bus.req_payload_i[0] = payload_t'(16'h1000 + c);
            bus.unit_out_valid_i = (c >= 2 && c < 5);
            bus.unit_result_i    = result_t'(16'hA000 + c - 2);
            settle();
            if (c < 3) begin
                check("s_unit_valid", 32'(bus.unit_valid_o), 32'h1);
                check("s_payload", 32'(bus.unit_payload_o), 32'h1000 + c);
                check("s_req_ready", 32'(bus.req_ready_o), 32'h1);
            end
            check("s_rsp_valid", 32'(bus.rsp_valid_o), (c >= 2 && c < 5) ? 32'h1 : 32'h0);
            if (c >= 2 && c < 5) check("s_rsp_result", 32'(bus.rsp_result_o), 32'hA000 + c - 2);
            check("s_cnt", 32'(dut.cnt_q), (c == 0) ? 0 : (c == 1) ? 1 : (c == 2) ? 2 :
                                            (c == 3) ? 2 : (c == 4) ? 1 : 0);
            next_cycle();
        end

        // Fairness: both requesters valid, grants alternate from 0.
        do_reset();
        bus.unit_ready_i = 1'b1;
        bus.rsp_ready_i  = 2'b11;
        for (int c = 0; c < 7; c++) begin
            bus.req_valid_i      = (c < 4) ? 2'b11 : 2'b00;
            bus.req_payload_i[0] = payload_t'(16'h2000 + c);
            bus.req_payload_i[1] = payload_t'(16'h2100 + c);
            bus.unit_out_valid_i = (c >= 2 && c < 6);
            settle();
            if (c < 4) begin
                check("f_req_ready", 32'(bus.req_ready_o), (c % 2 == 0) ? 32'h1 : 32'h2);
                check("f_payload", 32'(bus.unit_payload_o),
                      (c % 2 == 0) ? 32'h2000 + c : 32'h2100 + c);
            end
            if (c >= 2 && c < 6)
                check("f_rsp_valid", 32'(bus.rsp_valid_o), (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c == 6) check("f_cnt_end", 32'(dut.cnt_q), 32'h0);
            next_cycle();
        end

        // Stall lock on requester 1 while requester 0 shows up.
        idle_inputs();
        bus.req_valid_i      = 2'b10;
        bus.req_payload_i[1] = 16'h3100;
        bus.req_payload_i[0] = 16'h3000;
        settle();
        check("l_unit_valid", 32'(bus.unit_valid_o), 32'h1);
        check("l_req_ready0", 32'(bus.req_ready_o), 32'h0);
        next_cycle();
        bus.req_valid_i = 2'b11;
        for (int c = 0; c < 2; c++) begin
            settle();
            check("l_payload_held", 32'(bus.unit_payload_o), 32'h3100);
            check("l_req_ready_stall", 32'(bus.req_ready_o), 32'h0);
            next_cycle();
        end
        bus.unit_ready_i = 1'b1;
        settle();
        check("l_accept", 32'(bus.req_ready_o), 32'h2);
        check("l_accept_payload", 32'(bus.unit_payload_o), 32'h3100);
        next_cycle();
        settle();
        check("l_next_grant", 32'(bus.req_ready_o), 32'h1);
        check("l_next_payload", 32'(bus.unit_payload_o), 32'h3000);
        next_cycle();
        bus.req_valid_i      = 2'b00;
        bus.unit_ready_i     = 1'b0;
        bus.unit_out_valid_i = 1'b1;
        bus.rsp_ready_i      = 2'b11;
        settle();
        check("l_rsp_first", 32'(bus.rsp_valid_o), 32'h2);
        next_cycle();
        check("l_rsp_second", 32'(bus.rsp_valid_o), 32'h1);
        next_cycle();
        bus.unit_out_valid_i = 1'b0;

        // Full FIFO with responses blocked.
        bus.req_valid_i  = 2'b01;
        bus.unit_ready_i = 1'b1;
        bus.rsp_ready_i  = 2'b00;
        for (int c = 0; c < 4; c++) begin
            settle();
            check("u_accept", 32'(bus.req_ready_o), 32'h1);
            next_cycle();
        end
        settle();
        check("u_full_valid", 32'(bus.unit_valid_o), 32'h0);
        check("u_full_ready", 32'(bus.req_ready_o), 32'h0);
        check("u_full_cnt", 32'(dut.cnt_q), 32'h4);
        next_cycle();
        bus.unit_out_valid_i = 1'b1;
        bus.rsp_ready_i      = 2'b01;
        settle();
        check("u_pop_same_cycle_valid", 32'(bus.unit_valid_o), 32'h0);
        check("u_pop_out_ready", 32'(bus.unit_out_ready_o), 32'h1);
        next_cycle();
        bus.unit_out_valid_i = 1'b0;
        settle();
        check("u_resume_valid", 32'(bus.unit_valid_o), 32'h1);
        check("u_resume_cnt", 32'(dut.cnt_q), 32'h3);
        next_cycle();
        bus.req_valid_i      = 2'b00;
        bus.unit_out_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        bus.unit_out_valid_i = 1'b0;
        check("u_drained", 32'(dut.cnt_q), 32'h0);

        // Response backpressure with head ID 1.
        bus.req_valid_i      = 2'b10;
        bus.req_payload_i[1] = 16'h5100;
        settle();
        check("b_issue", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        bus.req_valid_i      = 2'b00;
        bus.unit_out_valid_i = 1'b1;
        bus.rsp_ready_i      = 2'b01;
        settle();
        check("b_rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
        check("b_out_ready_blocked", 32'(bus.unit_out_ready_o), 32'h0);
        next_cycle();
        check("b_no_pop", 32'(dut.cnt_q), 32'h1);
        bus.rsp_ready_i = 2'b10;
        settle();
        check("b_out_ready", 32'(bus.unit_out_ready_o), 32'h1);
        next_cycle();
        bus.unit_out_valid_i = 1'b0;
        check("b_popped", 32'(dut.cnt_q), 32'h0);

        // Flush with three in flight and a locked grant.
        bus.req_valid_i  = 2'b01;
        bus.unit_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) next_cycle();
        bus.req_valid_i  = 2'b10;
        bus.unit_ready_i = 1'b0;
        next_cycle();
        check("x_locked", 32'(dut.lock_q), 32'h1);
        check("x_cnt3", 32'(dut.cnt_q), 32'h3);
        bus.flush_i          = 1'b1;
        bus.unit_ready_i     = 1'b1;
        bus.unit_out_valid_i = 1'b1;
        bus.rsp_ready_i      = 2'b11;
        settle();
        check("x_unit_flush", 32'(bus.unit_flush_o), 32'h1);
        check("x_req_ready_forced", 32'(bus.req_ready_o), 32'h0);
        check("x_rsp_valid_forced", 32'(bus.rsp_valid_o), 32'h0);
        next_cycle();
        idle_inputs();
        settle();
        check("x_cnt_cleared", 32'(dut.cnt_q), 32'h0);
        check("x_lock_cleared", 32'(dut.lock_q), 32'h0);
        check("x_busy", 32'(bus.busy_o), 32'h0);
        check("x_unit_flush_off", 32'(bus.unit_flush_o), 32'h0);
        bus.req_valid_i  = 2'b11;
        bus.unit_ready_i = 1'b1;
        settle();
        check("x_prio_kept", 32'(bus.req_ready_o), 32'h2);
        next_cycle();
        idle_inputs();
        bus.unit_out_valid_i = 1'b1;
        bus.rsp_ready_i      = 2'b11;
        settle();
        check("x_rsp_after_flush", 32'(bus.rsp_valid_o), 32'h2);
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
